// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding,
// steering select values and default bus widths.
package mem_port_arbiter_pkg;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;
    localparam int CNT_W  = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester ports plus the shared memory bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory.
interface mem_port_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata;
    logic          a_done;
    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_rdata;
    logic          b_done;
    logic          sel;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
        output a_rdata, a_done, b_rdata, b_done, sel, mem_en, mem_we,
               mem_addr, mem_wdata, busy
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
        input  a_rdata, a_done, b_rdata, b_done, sel, mem_en, mem_we,
               mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin pick between two requesters; a masked request
// is ignored, and a tie goes to the port that did not win last.
module rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic mask_a,
    input  logic mask_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_sel
);
    logic a_ok, b_ok;

    always_comb begin
        a_ok        = a_req & ~mask_a;
        b_ok        = b_req & ~mask_b;
        grant_valid = a_ok | b_ok;
        if (a_ok && b_ok) grant_sel = ~last_grant;
        else              grant_sel = b_ok ? SEL_B : SEL_A;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory between
// instruction fetch (port A) and the MEM-stage load/store (port B).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    state_t             state, next_state;
    logic               sel_q, we_q, last_grant, load;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q, a_rdata_q, b_rdata_q;
    logic [CNT_W-1:0]   cnt;
    logic               grant_valid, grant_sel, mask_a, mask_b;

    // The port finishing in DONE cannot be re-granted in that same cycle.
    assign mask_a = (state == DONE) && (sel_q == SEL_A);
    assign mask_b = (state == DONE) && (sel_q == SEL_B);

    rr_pick u_pick (
        .a_req       (bus.a_req),
        .b_req       (bus.b_req),
        .mask_a      (mask_a),
        .mask_b      (mask_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: if (grant_valid) begin
                next_state = BUSY;
                load       = 1'b1;
            end
            BUSY: if (cnt == '0) next_state = DONE;
            DONE: begin
                if (grant_valid) begin
                    next_state = BUSY;
                    load       = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= SEL_A;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            last_grant <= SEL_B;
            cnt        <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                sel_q      <= grant_sel;
                addr_q     <= grant_sel ? bus.b_addr : bus.a_addr;
                we_q       <= grant_sel & bus.b_we;
                last_grant <= grant_sel;
                cnt        <= CNT_W'(MEM_LAT - 1);
                if (grant_sel) wdata_q <= bus.b_wdata;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == BUSY && cnt == '0) begin
                if (sel_q == SEL_B) b_rdata_q <= bus.mem_rdata;
                else                a_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.sel       = sel_q;
    assign bus.mem_en    = (state == BUSY);
    assign bus.mem_we    = (state == BUSY) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.a_done    = (state == DONE) && (sel_q == SEL_A);
    assign bus.b_done    = (state == DONE) && (sel_q == SEL_B);
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a grant-timestamp model of the arbitration rules.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if #(.DW(8), .AW(8)) bus  ();
    mem_port_arbiter_if #(.DW(8), .AW(8)) bus1 ();

    mem_port_arbiter #(.DW(8), .AW(8), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset), .bus(bus));
    mem_port_arbiter #(.DW(8), .AW(8), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_req = 0;  bus.a_addr = 0;  bus.b_req = 0;  bus.b_we = 0;
        bus.b_addr = 0; bus.b_wdata = 0; bus.mem_rdata = 0;
        bus1.a_req = 0;  bus1.a_addr = 0;  bus1.b_req = 0;  bus1.b_we = 0;
        bus1.b_addr = 0; bus1.b_wdata = 0; bus1.mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL rst_sel got=%b exp=0", bus.sel); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr got=%h exp=00", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=00", bus.mem_wdata); end
        checks++; if (bus.a_done !== 1'b0 || bus.b_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b%b exp=00", bus.a_done, bus.b_done); end
        checks++; if (bus.a_rdata !== 8'h00 || bus.b_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=00/00", bus.a_rdata, bus.b_rdata); end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        tick(); bus.a_req = 1; bus.a_addr = 8'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            bus.mem_rdata = (c == 2) ? 8'h5A : 8'h00;
            @(negedge clk);
            checks++; if (bus.mem_en !== (c <= 2)) begin errors++; $display("FAIL rd_mem_en c%0d got=%b exp=%b", c, bus.mem_en, (c <= 2)); end
            checks++; if (bus.a_done !== (c == 3)) begin errors++; $display("FAIL rd_a_done c%0d got=%b exp=%b", c, bus.a_done, (c == 3)); end
            if (c <= 2) begin
                checks++; if (bus.sel !== 1'b0 || bus.mem_addr !== 8'h10) begin errors++; $display("FAIL rd_steer c%0d got sel=%b addr=%h exp sel=0 addr=10", c, bus.sel, bus.mem_addr); end
            end
            if (c >= 3) begin
                checks++; if (bus.a_rdata !== 8'h5A) begin errors++; $display("FAIL rd_a_rdata c%0d got=%h exp=5a", c, bus.a_rdata); end
            end
            if (c == 3) bus.a_req = 0;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_idle got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_write_b();
        tick(); bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8'h20; bus.b_wdata = 8'hC3;
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.mem_we !== (c <= 2)) begin errors++; $display("FAIL wr_mem_we c%0d got=%b exp=%b", c, bus.mem_we, (c <= 2)); end
            checks++; if (bus.b_done !== (c == 3) || bus.a_done !== 1'b0) begin errors++; $display("FAIL wr_done c%0d got a=%b b=%b exp a=0 b=%b", c, bus.a_done, bus.b_done, (c == 3)); end
            if (c <= 2) begin
                checks++; if (bus.sel !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 8'h20 || bus.mem_wdata !== 8'hC3) begin
                    errors++; $display("FAIL wr_bus c%0d got sel=%b en=%b addr=%h wd=%h exp 1 1 20 c3", c, bus.sel, bus.mem_en, bus.mem_addr, bus.mem_wdata); end
            end
            if (c == 3) begin bus.b_req = 0; bus.b_we = 0; end
        end
    endtask

    task automatic test_round_robin();
        logic       exp_done;
        logic       exp_port;
        do_reset();
        tick(); bus.a_req = 1; bus.b_req = 1; bus.a_addr = 8'h01; bus.b_addr = 8'h02;
        for (int c = 1; c <= 12; c++) begin
            tick();
            @(negedge clk);
            exp_done = (c % 3 == 0);
            exp_port = (((c - 1) / 3) % 2) == 1;
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rr_bubble c%0d got busy=%b exp=1", c, bus.busy); end
            checks++; if (bus.a_done !== (exp_done && !exp_port) || bus.b_done !== (exp_done && exp_port)) begin
                errors++; $display("FAIL rr_done c%0d got a=%b b=%b exp a=%b b=%b", c, bus.a_done, bus.b_done, exp_done && !exp_port, exp_done && exp_port); end
            if (!exp_done) begin
                checks++; if (bus.sel !== exp_port || bus.mem_addr !== (exp_port ? 8'h02 : 8'h01)) begin
                    errors++; $display("FAIL rr_grant c%0d got sel=%b addr=%h exp sel=%b", c, bus.sel, bus.mem_addr, exp_port); end
            end
        end
        bus.a_req = 0; bus.b_req = 0;
        tick(); @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_end got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_done_mask();
        logic exp_en;
        tick(); bus.a_req = 1; bus.a_addr = 8'h30;
        for (int c = 1; c <= 7; c++) begin
            tick();
            @(negedge clk);
            exp_en = (c == 1 || c == 2 || c == 5 || c == 6);
            checks++; if (bus.busy !== (c != 4)) begin errors++; $display("FAIL mask_busy c%0d got=%b exp=%b", c, bus.busy, (c != 4)); end
            checks++; if (bus.mem_en !== exp_en) begin errors++; $display("FAIL mask_en c%0d got=%b exp=%b", c, bus.mem_en, exp_en); end
            checks++; if (bus.a_done !== (c == 3 || c == 7)) begin errors++; $display("FAIL mask_done c%0d got=%b exp=%b", c, bus.a_done, (c == 3 || c == 7)); end
            if (c == 7) bus.a_req = 0;
        end
    endtask

    task automatic test_reset_mid_busy();
        tick(); bus.b_req = 1; bus.b_we = 0; bus.b_addr = 8'h33;
        tick(); @(negedge clk);
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL arst_pre got mem_en=%b exp=1", bus.mem_en); end
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_immediate got en=%b busy=%b exp 0 0", bus.mem_en, bus.busy); end
        bus.b_req = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) reset = 1'b0;
            tick(); @(negedge clk);
            checks++; if (bus.b_done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_abort c%0d got done=%b busy=%b exp 0 0", c, bus.b_done, bus.busy); end
        end
        tick(); bus.b_req = 1; bus.b_addr = 8'h44;
        tick();
        tick(); bus.mem_rdata = 8'h77;
        tick(); bus.mem_rdata = 8'h00;
        @(negedge clk);
        checks++; if (bus.b_done !== 1'b1 || bus.b_rdata !== 8'h77) begin errors++; $display("FAIL arst_retry got done=%b rdata=%h exp 1 77", bus.b_done, bus.b_rdata); end
        bus.b_req = 0;
        tick(); @(negedge clk);
        checks++; if (bus.b_done !== 1'b0) begin errors++; $display("FAIL arst_pulse got done=%b exp=0", bus.b_done); end
    endtask

    task automatic test_lat1();
        logic exp_port;
        tick(); bus1.a_req = 1; bus1.a_addr = 8'h55;
        tick(); bus1.mem_rdata = 8'h99;
        @(negedge clk);
        checks++; if (bus1.mem_en !== 1'b1 || bus1.sel !== 1'b0 || bus1.mem_addr !== 8'h55) begin
            errors++; $display("FAIL lat1_busy got en=%b sel=%b addr=%h exp 1 0 55", bus1.mem_en, bus1.sel, bus1.mem_addr); end
        tick(); bus1.mem_rdata = 8'h00;
        @(negedge clk);
        checks++; if (bus1.a_done !== 1'b1 || bus1.a_rdata !== 8'h99) begin errors++; $display("FAIL lat1_done got done=%b rdata=%h exp 1 99", bus1.a_done, bus1.a_rdata); end
        bus1.a_req = 0;
        tick(); bus1.a_req = 1; bus1.b_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick(); @(negedge clk);
            exp_port = (((c - 1) / 2) % 2) == 0;
            checks++; if (bus1.b_done !== (c % 2 == 0 && exp_port) || bus1.a_done !== (c % 2 == 0 && !exp_port) || bus1.busy !== 1'b1) begin
                errors++; $display("FAIL lat1_b2b c%0d got a=%b b=%b busy=%b exp a=%b b=%b busy=1", c, bus1.a_done, bus1.b_done, bus1.busy, (c % 2 == 0 && !exp_port), (c % 2 == 0 && exp_port)); end
        end
        bus1.a_req = 0; bus1.b_req = 0;
    endtask

    task automatic test_random();
        int         g = -100;
        logic       p = SEL_A, last = SEL_B, we_m = 1'b0;
        logic       in_busy, in_done, ra, rb, w;
        logic [7:0] addr_m = 0, wd_m = 0, rd_m = 0, rnd_rd;
        clear_inputs();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            rnd_rd = 8'($urandom);
            bus.mem_rdata = rnd_rd;
            if (!bus.a_req && $urandom_range(2) == 0) begin bus.a_req = 1; bus.a_addr = 8'($urandom); end
            if (!bus.b_req && $urandom_range(2) == 0) begin
                bus.b_req = 1; bus.b_addr = 8'($urandom); bus.b_we = 1'($urandom); bus.b_wdata = 8'($urandom);
            end
            @(negedge clk);
            in_busy = (c >= g + 1) && (c <= g + LAT);
            in_done = (c == g + LAT + 1);
            checks++; if (bus.busy !== (in_busy || in_done) || bus.mem_en !== in_busy || bus.mem_we !== (in_busy && we_m)) begin
                errors++; $display("FAIL rnd_ctrl c%0d got busy=%b en=%b we=%b exp %b %b %b", c, bus.busy, bus.mem_en, bus.mem_we, in_busy || in_done, in_busy, in_busy && we_m); end
            checks++; if (bus.a_done !== (in_done && p == SEL_A) || bus.b_done !== (in_done && p == SEL_B)) begin
                errors++; $display("FAIL rnd_done c%0d got a=%b b=%b exp a=%b b=%b", c, bus.a_done, bus.b_done, in_done && p == SEL_A, in_done && p == SEL_B); end
            if (in_busy) begin
                checks++; if (bus.sel !== p || bus.mem_addr !== addr_m || (we_m && bus.mem_wdata !== wd_m)) begin
                    errors++; $display("FAIL rnd_bus c%0d got sel=%b addr=%h wd=%h exp sel=%b addr=%h wd=%h", c, bus.sel, bus.mem_addr, bus.mem_wdata, p, addr_m, wd_m); end
            end
            if (c == g + LAT) rd_m = rnd_rd;
            if (in_done) begin
                checks++; if ((p == SEL_A ? bus.a_rdata : bus.b_rdata) !== rd_m) begin
                    errors++; $display("FAIL rnd_rdata c%0d port=%b got=%h exp=%h", c, p, (p == SEL_A ? bus.a_rdata : bus.b_rdata), rd_m); end
                if (p == SEL_A) begin
                    if ($urandom_range(1) == 0) bus.a_req = 0;
                    else bus.a_addr = 8'($urandom);
                end else begin
                    if ($urandom_range(1) == 0) bus.b_req = 0;
                    else begin bus.b_addr = 8'($urandom); bus.b_we = 1'($urandom); bus.b_wdata = 8'($urandom); end
                end
            end
            if (!in_busy) begin
                ra = bus.a_req && !(in_done && p == SEL_A);
                rb = bus.b_req && !(in_done && p == SEL_B);
                if (ra || rb) begin
                    w      = (ra && rb) ? ~last : rb;
                    g      = c;
                    p      = w;
                    last   = w;
                    addr_m = w ? bus.b_addr : bus.a_addr;
                    we_m   = w & bus.b_we;
                    if (w) wd_m = bus.b_wdata;
                end
            end
        end
        clear_inputs();
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_b();
        test_round_robin();
        test_done_mask();
        test_reset_mid_busy();
        test_lat1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
